// File: rtl/apb_fifo_pkg.sv
// apb_fifo_slave shared types: FSM states, register offsets, FSR bit layout.
package apb_fifo_pkg;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    localparam logic [1:0] FSR_OFS = 2'd0;
    localparam logic [1:0] FWD_OFS = 2'd1;
    localparam logic [1:0] FRD_OFS = 2'd2;

    localparam int FSR_EMPTY   = 0;
    localparam int FSR_FULL    = 1;
    localparam int FSR_OVF     = 2;
    localparam int FSR_UDF     = 3;
    localparam int FSR_CNT_LSB = 8;

endpackage

// File: rtl/apb_fifo_slave_if.sv
// APB bus bundle between the peripheral-bus master and the FIFO completer.
interface apb_fifo_slave_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PENABLE;
    logic [31:0]       PWDATA;
    logic              PSEL;
    logic [31:0]       PRDATA;
    logic              PREADY;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_fifo_slave_fifo_core.sv
// Circular-buffer FIFO with combinational head; push when full and
// pop when empty are dropped here, the caller records the error.
module fifo_core #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rp];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer exposing a FIFO through status, push and pop registers,
// with one registered wait state on every transfer.
module apb_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_fifo_slave_if.slave   bus,
    output logic              fifo_full,
    output logic              fifo_empty
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state;
    logic              ovf;
    logic              udf;
    logic              pready;
    logic [31:0]       prdata;
    logic [ADDR_W-1:0] paddr;
    logic [1:0]        ofs;
    logic              start;
    logic              is_fsr;
    logic              is_fwd;
    logic              is_frd;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count;
    logic [31:0]       fsr;
    logic [31:0]       rd_val;
    logic              unused_bits;

    assign paddr  = bus.PADDR;
    assign ofs    = paddr[3:2];
    assign start  = (state == IDLE) & bus.PSEL & bus.PENABLE;
    assign is_fsr = (ofs == FSR_OFS);
    assign is_fwd = (ofs == FWD_OFS);
    assign is_frd = (ofs == FRD_OFS);
    assign push   = start & bus.PWRITE & is_fwd;
    assign pop    = start & ~bus.PWRITE & is_frd;

    assign bus.PREADY = pready;
    assign bus.PRDATA = prdata;

    assign unused_bits = ^{paddr, bus.PWDATA};

    fifo_core #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .pop   (pop),
        .wdata (bus.PWDATA[DATA_W-1:0]),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_comb begin
        fsr                          = '0;
        fsr[FSR_EMPTY]               = fifo_empty;
        fsr[FSR_FULL]                = fifo_full;
        fsr[FSR_OVF]                 = ovf;
        fsr[FSR_UDF]                 = udf;
        fsr[FSR_CNT_LSB +: 8]        = 8'(count);
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            is_fsr:  rd_val = fsr;
            is_frd:  rd_val = fifo_empty ? '0 : 32'(head);
            default: rd_val = '0;
        endcase
    end

    // Register op happens only on the IDLE->RESP edge, so a held
    // select cannot repeat it within the same response cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state  <= IDLE;
            pready <= 1'b0;
            prdata <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RESP;
                        pready <= 1'b1;
                        prdata <= bus.PWRITE ? '0 : rd_val;
                        if (push && fifo_full) begin
                            ovf <= 1'b1;
                        end
                        if (pop && fifo_empty) begin
                            udf <= 1'b1;
                        end
                        if (bus.PWRITE && is_fsr) begin
                            ovf <= ovf & ~bus.PWDATA[FSR_OVF];
                            udf <= udf & ~bus.PWDATA[FSR_UDF];
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    pready <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    pready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Self-checking bench for apb_fifo_slave: vector table, scoreboard queue,
// pointer-wrap and mid-transfer reset sequences.
module tb_apb_fifo_slave;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          ef;
        bit          ee;
    } vec_t;

    localparam logic [3:0] A_FSR = 4'h0;
    localparam logic [3:0] A_FWD = 4'h4;
    localparam logic [3:0] A_FRD = 4'h8;
    localparam logic [3:0] A_RSV = 4'hC;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    logic fifo_full;
    logic fifo_empty;

    int checks = 0;
    int failures = 0;

    vec_t        vecs[64];
    int          nvec = 0;
    logic [31:0] sb[$];
    logic [31:0] model[$];

    apb_fifo_slave_if #(.ADDR_W(4)) bus ();

    apb_fifo_slave #(
        .DEPTH  (8),
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .bus        (bus.slave),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input bit wr, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp,
                       input bit ef, input bit ee);
        vecs[nvec] = '{wr, addr, wd, exp, ef, ee};
        nvec++;
    endtask

    // setup cycle, then access until PREADY; PREADY must rise on the
    // first edge of the access phase and last exactly one cycle
    task automatic xfer(input bit wr, input logic [3:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
        int n;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wd;
        @(posedge PCLK); #1;
        check("setup_pready", {31'b0, bus.PREADY}, 32'd0);
        bus.PENABLE = 1'b1;
        n = 0;
        do begin
            @(posedge PCLK); #1;
            n++;
        end while (!bus.PREADY && n < 8);
        check("pready_latency", n, 1);
        rd = bus.PRDATA;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("pready_one_cycle", {31'b0, bus.PREADY}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] e;
        int          n;

        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;

        add(0, A_FSR, 0, 32'h1, 0, 1);
        add(1, A_FWD, 32'h11, 0, 0, 0);
        add(1, A_FWD, 32'h22, 0, 0, 0);
        add(1, A_FWD, 32'h33, 0, 0, 0);
        add(0, A_FSR, 0, 32'h300, 0, 0);
        add(0, A_FRD, 0, 32'h11, 0, 0);
        add(0, A_FRD, 0, 32'h22, 0, 0);
        add(0, A_FRD, 0, 32'h33, 0, 1);
        add(0, A_FSR, 0, 32'h1, 0, 1);
        for (int i = 0; i < 8; i++)
            add(1, A_FWD, 32'hA0 + i, 0, i == 7, 0);
        add(0, A_FSR, 0, 32'h802, 1, 0);
        add(1, A_FWD, 32'hFF, 0, 1, 0);
        add(0, A_FSR, 0, 32'h806, 1, 0);
        for (int i = 0; i < 8; i++)
            add(0, A_FRD, 0, 32'hA0 + i, 0, i == 7);
        add(0, A_FSR, 0, 32'h5, 0, 1);
        add(1, A_FSR, 32'hC, 0, 0, 1);
        add(0, A_FSR, 0, 32'h1, 0, 1);
        add(0, A_FRD, 0, 32'h0, 0, 1);
        add(0, A_FSR, 0, 32'h9, 0, 1);
        add(1, A_FSR, 32'hC, 0, 0, 1);
        add(0, A_FSR, 0, 32'h1, 0, 1);
        add(0, A_FWD, 0, 32'h0, 0, 1);
        add(0, A_RSV, 0, 32'h0, 0, 1);
        add(1, A_FRD, 32'h55, 0, 0, 1);
        add(1, A_RSV, 32'h77, 0, 0, 1);
        add(0, A_FSR, 0, 32'h1, 0, 1);

        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        check("rst_pready", {31'b0, bus.PREADY}, 32'd0);
        check("rst_prdata", bus.PRDATA, 32'd0);
        check("rst_empty", {31'b0, fifo_empty}, 32'd1);
        check("rst_full", {31'b0, fifo_full}, 32'd0);

        for (int i = 0; i < nvec; i++) begin
            sb.push_back(vecs[i].exp);
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd);
            e = sb.pop_front();
            check($sformatf("vec%0d_prdata", i), rd, e);
            check($sformatf("vec%0d_full", i), {31'b0, fifo_full},
                  {31'b0, vecs[i].ef});
            check($sformatf("vec%0d_empty", i), {31'b0, fifo_empty},
                  {31'b0, vecs[i].ee});
        end

        for (int i = 1; i <= 5; i++) begin
            xfer(1, A_FWD, i, rd);
            model.push_back(i);
            xfer(0, A_FRD, 0, rd);
            e = model.pop_front();
            check($sformatf("wrap%0d_data", i), rd, e);
        end
        xfer(0, A_FSR, 0, rd);
        check("wrap_fsr", rd, 32'h1);

        xfer(0, A_FRD, 0, rd);
        check("pre_rst_underflow", rd, 32'h0);
        for (int i = 0; i < 3; i++)
            xfer(1, A_FWD, 32'h40 + i, rd);
        xfer(0, A_FSR, 0, rd);
        check("pre_rst_fsr", rd, 32'h308);

        @(posedge PCLK); #1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = A_FWD;
        bus.PWDATA  = 32'h99;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        PRESET      = 1'b1;
        @(posedge PCLK); #1;
        check("midrst_pready", {31'b0, bus.PREADY}, 32'd0);
        check("midrst_empty", {31'b0, fifo_empty}, 32'd1);
        PRESET      = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        n = 0;
        xfer(0, A_FSR, 0, rd);
        check("midrst_fsr", rd, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
